dbg_frame_tx: RTL and testbench
===============================

Name: dbg_frame_tx

Overview:
Transmit side of the on-chip debug path. On a snapshot request it latches the debug words produced by the accelerator's debug-capture logic (sticky stage vld/rdy flags, probe data, build tag) into a shadow buffer. It then streams them out as a framed valid/ready word stream to the host readout path (UART/AXIS bridge). Each frame is: header, NUM_WORDS payload words, XOR checksum.

Parameters:
NUM_WORDS, 3, number of 32-bit debug words per frame (1..15)
DATA_W, 32, width of each debug word and of the output stream
HDR_MAGIC, 16'hD5B6, upper 16 bits of every header word
CNT_W, 16, width of frame sequence and drop counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_i  input  1  snapshot request, single-cycle pulse
dbg_i  input  [NUM_WORDS-1:0][DATA_W-1:0]  live debug words; dbg_i[0] is sent first
busy_o  output  1  high while a frame is pending or in flight
tx_data_o  output  DATA_W  stream data
tx_vld_o  output  1  stream valid
tx_last_o  output  1  high on the checksum beat only
tx_rdy_i  input  1  stream ready from sink
frame_cnt_o  output  CNT_W  number of frames fully sent
drop_cnt_o  output  CNT_W  number of requests ignored while busy

Behaviour:
- Clock/reset: single clock clk. rst is synchronous, active-high, sampled on posedge clk.
- Reset values: tx_vld_o=0, tx_last_o=0, tx_data_o=0, busy_o=0, frame_cnt_o=0, drop_cnt_o=0, FSM=IDLE, shadow buffer=0.
- FSM states: IDLE, HDR, DATA, CSUM.
- IDLE: if req_i=1 at edge t, latch all of dbg_i into the shadow buffer at edge t, clear the word index and checksum, and go to HDR. At t+1, tx_vld_o=1 and busy_o=1 (one-cycle request-to-valid latency).
- HDR: tx_data_o = {HDR_MAGIC, frame_cnt_o[15:0]}. On the accepted beat (vld&&rdy): checksum <= header, go to DATA.
- DATA: tx_data_o = shadow[idx]. On each accepted beat: checksum ^= word, idx++. After the beat with idx=NUM_WORDS-1 is accepted, go to CSUM.
- CSUM: tx_data_o = checksum, tx_last_o=1. On the accepted beat: frame_cnt_o++ and go to IDLE. busy_o=0 from the next cycle.
- Handshake rules:
  - tx_data_o and tx_last_o are held stable while tx_vld_o=1 and tx_rdy_i=0.
  - tx_vld_o never drops mid-frame without acceptance.
  - Back-to-back beats run at 1 beat/cycle when tx_rdy_i is held high, giving NUM_WORDS+2 cycles per frame.
- Snapshot isolation: dbg_i changes after the latch edge do not affect the frame in flight.
- req_i while busy (HDR/DATA/CSUM, including the cycle the CSUM beat is accepted): the request is not queued, and drop_cnt_o increments.
- Counter widths: frame_cnt_o wraps 0xFFFF -> 0x0000, so the header sequence wraps too. drop_cnt_o saturates at 0xFFFF.
- Simultaneous events:
  - rst together with anything: reset wins.
  - rst asserted mid-frame aborts the frame. tx_vld_o is 0 from the next cycle, the partial frame is not counted, and no tx_last_o is emitted.
- tx_rdy_i while tx_vld_o=0 is ignored.

Decomposition:
- Shared debug package dbg_pkg:
  - enum dbg_tx_state_e {IDLE, HDR, DATA, CSUM}
  - localparams DBG_HDR_MAGIC, DBG_DATA_W
  - function dbg_hdr(seq) returning the header word
- No sub-module is required. The shadow buffer and checksum stay inline; total RTL is about 150 lines.

Test Plan:
1. Basic frame: NUM_WORDS=3, dbg_i={0x00C74FD7,0x000000A5,0x0000000C} (index 2..0), req_i pulse, tx_rdy_i=1 -> beats 0xD5B60000, 0x0000000C, 0x000000A5, 0x00C74FD7, 0xD5714F7E (tx_last_o=1). frame_cnt_o=1; tx_vld_o rises 1 cycle after req_i.
2. Backpressure: same frame with tx_rdy_i toggling randomly -> identical 5-beat sequence with data stable while stalled, and exactly one tx_last_o.
3. Snapshot isolation plus drop: change dbg_i and pulse req_i 3 times mid-frame -> payload equals the latched values, drop_cnt_o=3, frame_cnt_o=1, and no second frame.
4. Sequence wrap: preload by sending 65536 frames (or force frame_cnt_o=0xFFFF) -> the next header is 0xD5B6FFFF, the following header is 0xD5B60000, and frame_cnt_o wraps to 0.
5. Reset mid-frame: assert rst during the DATA beat idx=1 -> tx_vld_o=0 and busy_o=0 next cycle, with frame_cnt_o=0 and drop_cnt_o=0. A new req_i then yields a clean frame with header 0xD5B60000.
6. Drop saturation: hold frame busy (tx_rdy_i=0) and pulse req_i 70000 times -> drop_cnt_o stops at 0xFFFF.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and helpers for the on-chip debug readout path.
package dbg_pkg;

    localparam int          DBG_DATA_W    = 32;
    localparam logic [15:0] DBG_HDR_MAGIC = 16'hD5B6;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CSUM
    } dbg_tx_state_e;

    // Header word: magic in the upper half, frame sequence number in the lower half.
    function automatic logic [DBG_DATA_W-1:0] dbg_hdr(
        input logic [15:0] seq,
        input logic [15:0] magic = DBG_HDR_MAGIC
    );
        return {magic, seq};
    endfunction

endpackage

// File: rtl/dbg_frame_tx.sv
// Debug snapshot transmitter: latches debug words on request and streams them
// out as header, payload words and XOR checksum over a valid/ready interface.
module dbg_frame_tx
    import dbg_pkg::*;
#(
    parameter int          NUM_WORDS = 3,
    parameter int          DATA_W    = 32,
    parameter logic [15:0] HDR_MAGIC = 16'hD5B6,
    parameter int          CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_i,
    input  logic [NUM_WORDS-1:0][DATA_W-1:0] dbg_i,
    output logic                             busy_o,
    output logic [DATA_W-1:0]                tx_data_o,
    output logic                             tx_vld_o,
    output logic                             tx_last_o,
    input  logic                             tx_rdy_i,
    output logic [CNT_W-1:0]                 frame_cnt_o,
    output logic [CNT_W-1:0]                 drop_cnt_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    dbg_tx_state_e                    r_state;
    logic [NUM_WORDS-1:0][DATA_W-1:0] r_shadow;
    logic [IDX_W-1:0]                 r_idx;
    logic [DATA_W-1:0]                r_csum;
    logic [DATA_W-1:0]                r_data;
    logic                             r_vld;
    logic                             r_last;
    logic                             r_busy;
    logic [CNT_W-1:0]                 r_frame_cnt;
    logic [CNT_W-1:0]                 r_drop_cnt;

    logic                             w_acc;
    logic [IDX_W-1:0]                 w_idx_nxt;

    assign w_acc     = r_vld && tx_rdy_i;
    assign w_idx_nxt = r_idx + IDX_W'(1);

    // r_data always holds the beat currently offered, so the next beat is loaded on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_data      <= '0;
            r_vld       <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (req_i && (r_state != IDLE) && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_shadow <= dbg_i;
                        r_idx    <= '0;
                        r_csum   <= '0;
                        r_data   <= dbg_hdr(r_frame_cnt[15:0], HDR_MAGIC);
                        r_vld    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= HDR;
                    end
                end
                HDR: begin
                    if (w_acc) begin
                        r_csum  <= r_data;
                        r_idx   <= '0;
                        r_data  <= r_shadow[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        r_csum <= r_csum ^ r_data;
                        if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
                            r_data  <= r_csum ^ r_data;
                            r_last  <= 1'b1;
                            r_state <= CSUM;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_data <= r_shadow[w_idx_nxt];
                        end
                    end
                end
                CSUM: begin
                    if (w_acc) begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_vld       <= 1'b0;
                        r_last      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign tx_data_o   = r_data;
    assign tx_vld_o    = r_vld;
    assign tx_last_o   = r_last;
    assign frame_cnt_o = r_frame_cnt;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_dbg_frame_tx.sv
// Randomized bench for dbg_frame_tx against a frame-level reference model.
module tb_dbg_frame_tx;

    localparam int NW = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_i;
    logic [NW-1:0][31:0] dbg_i;
    logic               busy_o;
    logic [31:0]        tx_data_o;
    logic               tx_vld_o;
    logic               tx_last_o;
    logic               tx_rdy_i;
    logic [15:0]        frame_cnt_o;
    logic [15:0]        drop_cnt_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_frames;
    logic [15:0] m_drops;

    dbg_frame_tx #(
        .NUM_WORDS(NW),
        .DATA_W   (32),
        .HDR_MAGIC(16'hD5B6),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .dbg_i      (dbg_i),
        .busy_o     (busy_o),
        .tx_data_o  (tx_data_o),
        .tx_vld_o   (tx_vld_o),
        .tx_last_o  (tx_last_o),
        .tx_rdy_i   (tx_rdy_i),
        .frame_cnt_o(frame_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        req_i    = 1'b0;
        tx_rdy_i = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        m_frames = '0;
        m_drops  = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_vld"},   {31'd0, tx_vld_o},  32'd0);
        chk({tag, "_busy"},  {31'd0, busy_o},    32'd0);
        chk({tag, "_last"},  {31'd0, tx_last_o}, 32'd0);
        chk({tag, "_frame"}, {16'd0, frame_cnt_o}, {16'd0, m_frames});
        chk({tag, "_drop"},  {16'd0, drop_cnt_o},  {16'd0, m_drops});
    endtask

    // Sends one frame. Requests are pulsed every other cycle (n_drop of them)
    // while the frame is in flight; the sink stalls for the first 'stall' cycles.
    task automatic run_frame(input logic [31:0] w [NW], input bit rand_rdy,
                             input int n_drop, input int stall);
        logic [31:0] exp_q[$];
        logic [31:0] x;
        logic [31:0] pd;
        logic        pl;
        bit          pstall;
        int          k;
        int          c;
        int          dsum;

        x = {16'hD5B6, m_frames};
        exp_q.push_back(x);
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(w[i]);
            x ^= w[i];
        end
        exp_q.push_back(x);

        @(negedge clk);
        chk("pre_req_vld", {31'd0, tx_vld_o}, 32'd0);
        for (int i = 0; i < NW; i++) dbg_i[i] = w[i];
        req_i    = 1'b1;
        tx_rdy_i = 1'b0;
        @(negedge clk);
        chk("req_to_vld",  {31'd0, tx_vld_o}, 32'd1);
        chk("req_to_busy", {31'd0, busy_o},   32'd1);

        k = 0; c = 0; pstall = 1'b0; pd = '0; pl = 1'b0;
        while (k < NW + 2 && c < 400) begin
            for (int i = 0; i < NW; i++) dbg_i[i] = $urandom;
            req_i = ((c % 2) == 0) && ((c / 2) < n_drop);
            if (c < stall)      tx_rdy_i = 1'b0;
            else if (rand_rdy)  tx_rdy_i = 1'($urandom_range(0, 1));
            else                tx_rdy_i = 1'b1;
            chk("vld_in_frame", {31'd0, tx_vld_o}, 32'd1);
            if (pstall) begin
                chk("hold_data", tx_data_o, pd);
                chk("hold_last", {31'd0, tx_last_o}, {31'd0, pl});
            end
            if (tx_vld_o && tx_rdy_i) begin
                chk($sformatf("beat%0d", k), tx_data_o, exp_q[k]);
                chk($sformatf("last%0d", k), {31'd0, tx_last_o}, (k == NW + 1) ? 32'd1 : 32'd0);
                k++;
                pstall = 1'b0;
            end else begin
                pstall = tx_vld_o;
            end
            pd = tx_data_o;
            pl = tx_last_o;
            c++;
            @(negedge clk);
        end
        req_i    = 1'b0;
        tx_rdy_i = 1'b0;
        chk("frame_timeout", k, NW + 2);

        m_frames = m_frames + 16'd1;
        dsum = int'(m_drops) + n_drop;
        m_drops = (dsum > 65535) ? 16'hFFFF : 16'(dsum);
        check_idle("post_frame");
        repeat (3) @(negedge clk);
        chk("no_second_frame", {31'd0, tx_vld_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] w [NW];

        rst = 1'b1; req_i = 1'b0; tx_rdy_i = 1'b0; dbg_i = '0;
        m_frames = '0; m_drops = '0;
        repeat (2) @(negedge clk);
        chk("rst_data", tx_data_o, 32'd0);
        check_idle("rst");
        rst = 1'b0;

        // basic frame at full rate
        w[0] = 32'h0000000C; w[1] = 32'h000000A5; w[2] = 32'h00C74FD7;
        run_frame(w, 1'b0, 0, 0);

        // same content under random backpressure
        run_frame(w, 1'b1, 0, 0);

        // snapshot isolation with requests dropped mid-frame
        for (int i = 0; i < NW; i++) w[i] = $urandom;
        run_frame(w, 1'b0, 3, 0);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NW; i++) w[i] = $urandom;
            run_frame(w, 1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
        end

        // sequence number wrap
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        m_frames = 16'hFFFF;
        @(negedge clk);
        chk("preload_frame", {16'd0, frame_cnt_o}, 32'h0000FFFF);
        for (int i = 0; i < NW; i++) w[i] = $urandom;
        run_frame(w, 1'b1, 0, 0);
        chk("wrap_frame", {16'd0, frame_cnt_o}, 32'd0);
        run_frame(w, 1'b0, 0, 0);

        // reset during payload word 1
        for (int i = 0; i < NW; i++) w[i] = $urandom;
        @(negedge clk);
        for (int i = 0; i < NW; i++) dbg_i[i] = w[i];
        req_i = 1'b1; tx_rdy_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_word1", tx_data_o, w[1]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_rdy_i = 1'b0;
        m_frames = '0; m_drops = '0;
        check_idle("abort");
        for (int i = 0; i < NW; i++) w[i] = $urandom;
        run_frame(w, 1'b0, 0, 0);

        // drop counter saturation while the sink stalls
        @(negedge clk);
        force dut.r_drop_cnt = 16'hFFF0;
        @(negedge clk);
        release dut.r_drop_cnt;
        m_drops = 16'hFFF0;
        @(negedge clk);
        chk("preload_drop", {16'd0, drop_cnt_o}, 32'h0000FFF0);
        for (int i = 0; i < NW; i++) w[i] = $urandom;
        run_frame(w, 1'b0, 20, 40);
        chk("drop_sat", {16'd0, drop_cnt_o}, 32'h0000FFFF);

        // full reset then one more clean frame
        do_reset();
        check_idle("rst2");
        for (int i = 0; i < NW; i++) w[i] = $urandom;
        run_frame(w, 1'b1, 1, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
